dec_local_ni: RTL

- Local network interface for one node of the bufferless deflection (DEC) router.
- Injection side: buffers flits from the core, computes the productive vector (PV) for each flit, and drives the router's local injection port (dinLocal/PVLocal) whenever the router grants an injection slot.
- Ejection side: captures flits the router ejects on doutLocal and presents them to the core through a valid/ready FIFO.
- Also tracks injection starvation and ejection overflow.

---
 rtl/dec_local_ni.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dec_local_ni.sv
// Local network interface for a DEC deflection router node. It buffers core flits for injection,
// computes their productive vector, and queues ejected flits for the core.
module dec_local_ni #(
  parameter int unsigned WIDTH_PORT    = 64,
  parameter int unsigned WIDTH_PV      = 5,
  parameter int unsigned POS_VALID     = 63,
  parameter int unsigned COORD_W       = 3,
  parameter int unsigned POS_X_DST_LSB = 56,
  parameter int unsigned POS_Y_DST_LSB = 53,
  parameter int unsigned CORD_X        = 0,
  parameter int unsigned CORD_Y        = 0,
  parameter int unsigned INJ_DEPTH     = 4,
  parameter int unsigned EJ_DEPTH      = 4,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH_PORT-1:0] core_tx_data,
  input  logic                  core_tx_valid,
  output logic                  core_tx_ready,
  input  logic                  inj_ok,
  output logic [WIDTH_PORT-1:0] dinLocal,
  output logic [WIDTH_PV-1:0]   PVLocal,
  input  logic [WIDTH_PORT-1:0] doutLocal,
  output logic [WIDTH_PORT-1:0] core_rx_data,
  output logic                  core_rx_valid,
  input  logic                  core_rx_ready,
  output logic                  starve,
  output logic                  ej_overflow,
  output logic [15:0]           inj_count,
  output logic [7:0]            ej_drop_count
);

  localparam int unsigned InjAw = $clog2(INJ_DEPTH);
  localparam int unsigned InjPw = InjAw + 1;
  localparam int unsigned EjAw  = $clog2(EJ_DEPTH);
  localparam int unsigned EjPw  = EjAw + 1;
  localparam int unsigned StW   = $clog2(STARVE_LIMIT + 1);

  localparam logic [COORD_W-1:0] CordX  = COORD_W'(CORD_X);
  localparam logic [COORD_W-1:0] CordY  = COORD_W'(CORD_Y);
  localparam logic [StW-1:0]     StLim  = StW'(STARVE_LIMIT);

  // Injection FIFO
  logic [WIDTH_PORT-1:0] inj_mem [INJ_DEPTH];
  logic [InjPw-1:0]      inj_wr_q, inj_rd_q;
  logic                  inj_empty, inj_full, inj_push, inj_pop;
  logic [WIDTH_PORT-1:0] inj_wdata, inj_head;

  assign inj_empty     = (inj_wr_q == inj_rd_q);
  assign inj_full      = (inj_wr_q[InjAw] != inj_rd_q[InjAw]) &&
                         (inj_wr_q[InjAw-1:0] == inj_rd_q[InjAw-1:0]);
  assign core_tx_ready = !inj_full;
  assign inj_push      = core_tx_valid && !inj_full;
  assign inj_pop       = !inj_empty && inj_ok;
  assign inj_head      = inj_mem[inj_rd_q[InjAw-1:0]];

  always_comb begin
    inj_wdata            = core_tx_data;
    inj_wdata[POS_VALID] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (inj_push) begin
      inj_mem[inj_wr_q[InjAw-1:0]] <= inj_wdata;
    end
  end

  // Productive vector of the FIFO head: [0]N [1]E [2]S [3]W [4]Local
  logic [COORD_W-1:0]  dst_x, dst_y;
  logic [WIDTH_PV-1:0] pv;

  assign dst_x = inj_head[POS_X_DST_LSB +: COORD_W];
  assign dst_y = inj_head[POS_Y_DST_LSB +: COORD_W];

  always_comb begin
    pv = '0;
    if (dst_y > CordY) pv[0] = 1'b1;
    if (dst_x > CordX) pv[1] = 1'b1;
    if (dst_y < CordY) pv[2] = 1'b1;
    if (dst_x < CordX) pv[3] = 1'b1;
    if ((dst_x == CordX) && (dst_y == CordY)) pv[4] = 1'b1;
  end

  // Starvation counter saturates; clears on injection or when nothing is waiting
  logic [StW-1:0] scnt_q, scnt_d;

  always_comb begin
    if (inj_pop || inj_empty) begin
      scnt_d = '0;
    end else if (scnt_q == StLim) begin
      scnt_d = scnt_q;
    end else begin
      scnt_d = scnt_q + StW'(1);
    end
  end

  logic [WIDTH_PORT-1:0] din_q;
  logic [WIDTH_PV-1:0]   pv_q;
  logic                  starve_q;
  logic [15:0]           inj_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_wr_q    <= '0;
      inj_rd_q    <= '0;
      din_q       <= '0;
      pv_q        <= '0;
      scnt_q      <= '0;
      starve_q    <= 1'b0;
      inj_count_q <= '0;
    end else begin
      if (inj_push) inj_wr_q <= inj_wr_q + InjPw'(1);
      if (inj_pop) begin
        inj_rd_q    <= inj_rd_q + InjPw'(1);
        din_q       <= inj_head;
        pv_q        <= pv;
        inj_count_q <= inj_count_q + 16'd1;
      end else begin
        din_q <= '0;
        pv_q  <= '0;
      end
      scnt_q   <= scnt_d;
      starve_q <= (scnt_d == StLim);
    end
  end

  assign dinLocal  = din_q;
  assign PVLocal   = pv_q;
  assign starve    = starve_q;
  assign inj_count = inj_count_q;

  // Ejection FIFO: first-word-fall-through; the router cannot be stalled, so overflow drops
  logic [WIDTH_PORT-1:0] ej_mem [EJ_DEPTH];
  logic [EjPw-1:0]       ej_wr_q, ej_rd_q;
  logic                  ej_empty, ej_full, ej_in, ej_push, ej_pop, ej_drop;
  logic                  ej_ovf_q;
  logic [7:0]            ej_drop_q;

  assign ej_empty = (ej_wr_q == ej_rd_q);
  assign ej_full  = (ej_wr_q[EjAw] != ej_rd_q[EjAw]) &&
                    (ej_wr_q[EjAw-1:0] == ej_rd_q[EjAw-1:0]);
  assign ej_in    = doutLocal[POS_VALID];
  assign ej_pop   = !ej_empty && core_rx_ready;
  assign ej_push  = ej_in && (!ej_full || ej_pop);
  assign ej_drop  = ej_in && ej_full && !ej_pop;

  assign core_rx_valid = !ej_empty;
  assign core_rx_data  = ej_mem[ej_rd_q[EjAw-1:0]];

  always_ff @(posedge clk) begin
    if (ej_push) begin
      ej_mem[ej_wr_q[EjAw-1:0]] <= doutLocal;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ej_wr_q   <= '0;
      ej_rd_q   <= '0;
      ej_ovf_q  <= 1'b0;
      ej_drop_q <= '0;
    end else begin
      if (ej_push) ej_wr_q <= ej_wr_q + EjPw'(1);
      if (ej_pop)  ej_rd_q <= ej_rd_q + EjPw'(1);
      if (ej_drop) begin
        ej_ovf_q <= 1'b1;
        if (ej_drop_q != 8'hff) ej_drop_q <= ej_drop_q + 8'd1;
      end
    end
  end

  assign ej_overflow   = ej_ovf_q;
  assign ej_drop_count = ej_drop_q;

endmodule
